// File: rtl/pmod_walker_pkg.sv
// Shared types and helpers for the pmod_walker LED/PMOD pattern engine.
package pmod_walker_pkg;

    typedef enum logic [1:0] {
        MODE_STEP   = 2'd0,
        MODE_RUN    = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_t;

    function automatic int pos_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pmod_walker_btn_debounce.sv
// Button path: 2-FF synchroniser, stable-sample debouncer, press pulse.
import pmod_walker_pkg::*;

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_N,
    output logic level_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1_q, s2_q;
    logic          lvl_q, lvl_prev_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            lvl_q      <= 1'b1;
            lvl_prev_q <= 1'b1;
            press_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_q       <= BTN_N;
            s2_q       <= s1_q;
            lvl_prev_q <= lvl_q;
            press_q    <= lvl_prev_q & ~lvl_q;
            // any sample matching the accepted level restarts the count
            if (s2_q != lvl_q) begin
                if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    lvl_q <= s2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign level_n = lvl_q;
    assign press   = press_q;

endmodule

// File: rtl/pmod_walker.sv
// LED/PMOD pattern engine: step, run, bounce and binary count modes.
// Define PMOD_WALKER_LONGPRESS_EN to make a long hold reverse direction.
import pmod_walker_pkg::*;

module pmod_walker #(
    parameter int N_OUT           = 24,
    parameter int LOG2DELAY       = 20,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 2**22
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      BTN_N,
    input  logic [1:0]                MODE,
    output logic [N_OUT-1:0]          OUT,
    output logic [pos_w(N_OUT)-1:0]   POS,
    output logic                      LED_N
);

    localparam int PW = pos_w(N_OUT);
    localparam logic [PW-1:0] PMAX = PW'(N_OUT - 1);

    logic [LOG2DELAY-1:0] pre_q;
    mode_t                mode_q, mode_l_q;
    logic [PW-1:0]        pos_q, step_d;
    logic                 dir_q, paused_q, paused_d;
    logic [N_OUT-1:0]     cnt_q;
    logic                 level_n, press, tick, chg, flip;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .CLK    (CLK),
        .RST    (RST),
        .BTN_N  (BTN_N),
        .level_n(level_n),
        .press  (press)
    );

    function automatic logic [PW-1:0] adv(
        input logic [PW-1:0] p,
        input logic          down
    );
        if (down)
            return (p == '0) ? PMAX : p - 1'b1;
        return (p == PMAX) ? '0 : p + 1'b1;
    endfunction

    assign tick     = &pre_q;
    assign chg      = (mode_q != mode_l_q);
    assign paused_d = paused_q ^ press;
    assign step_d   = adv(pos_q, dir_q);

`ifdef PMOD_WALKER_LONGPRESS_EN
    localparam int HW = $clog2(LONG_CYCLES + 1);
    logic [HW-1:0] hold_q;

    // saturates at LONG_CYCLES so one hold reverses exactly once
    always_ff @(posedge CLK) begin
        if (RST || level_n)
            hold_q <= '0;
        else if (hold_q != HW'(LONG_CYCLES))
            hold_q <= hold_q + 1'b1;
    end

    assign flip = !level_n
               && (hold_q == HW'(LONG_CYCLES - 1))
               && (mode_q == MODE_STEP || mode_q == MODE_RUN);
`else
    assign flip = (LONG_CYCLES < 0);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre_q    <= '0;
            mode_q   <= MODE_STEP;
            mode_l_q <= MODE_STEP;
            pos_q    <= '0;
            dir_q    <= 1'b0;
            paused_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pre_q    <= pre_q + 1'b1;
            mode_q   <= mode_t'(MODE);
            mode_l_q <= mode_q;
            if (chg) begin
                pos_q    <= '0;
                dir_q    <= 1'b0;
                paused_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                unique case (mode_q)
                    MODE_STEP: begin
                        if (press)
                            pos_q <= step_d;
                    end
                    MODE_RUN: begin
                        paused_q <= paused_d;
                        if (tick && !paused_d)
                            pos_q <= step_d;
                    end
                    MODE_BOUNCE: begin
                        paused_q <= paused_d;
                        if (tick && !paused_d) begin
                            if (!dir_q && pos_q == PMAX) begin
                                dir_q <= 1'b1;
                                pos_q <= PMAX - 1'b1;
                            end else if (dir_q && pos_q == '0) begin
                                dir_q <= 1'b0;
                                pos_q <= PW'(1);
                            end else begin
                                pos_q <= step_d;
                            end
                        end
                    end
                    MODE_COUNT: begin
                        if (press)
                            cnt_q <= '0;
                        else if (tick)
                            cnt_q <= cnt_q + 1'b1;
                    end
                endcase
                if (flip)
                    dir_q <= ~dir_q;
            end
        end
    end

    assign OUT   = (mode_q == MODE_COUNT) ? cnt_q : (N_OUT'(1) << pos_q);
    assign POS   = pos_q;
    assign LED_N = level_n;

endmodule

// File: tb/tb_pmod_walker.sv
// Bench for pmod_walker: directed scenarios plus random button/mode traffic.
module tb_pmod_walker;

    localparam int NO = 8;
    localparam int LD = 3;
    localparam int DB = 4;
    localparam int LC = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          BTN_N = 1'b1;
    logic [1:0]    MODE = 2'd0;
    logic [NO-1:0] OUT;
    logic [2:0]    POS;
    logic          LED_N;

    int checks = 0;
    int errors = 0;

    int s1, s2, deb, debp, run, prs, pre, mr, ml;
    int pos, dir, paused, cnt, hold;

    pmod_walker #(
        .N_OUT          (NO),
        .LOG2DELAY      (LD),
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LC)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .BTN_N(BTN_N),
        .MODE (MODE),
        .OUT  (OUT),
        .POS  (POS),
        .LED_N(LED_N)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic int m_out();
        return (mr == 3) ? cnt : (1 << pos);
    endfunction

    // behavioural model, advanced once per clock edge
    task automatic model_step(input bit r, input bit b, input int m);
        int  o_deb, o_s2, o_press;
        bit  tk, ch, fl;
        if (r) begin
            s1 = 1; s2 = 1; deb = 1; debp = 1; run = 0; prs = 0;
            pre = 0; mr = 0; ml = 0;
            pos = 0; dir = 0; paused = 0; cnt = 0; hold = 0;
            return;
        end
        tk = (pre == (1 << LD) - 1);
        ch = (mr != ml);
        o_deb = deb;
        o_s2 = s2;
        o_press = prs;
        fl = 0;
`ifdef PMOD_WALKER_LONGPRESS_EN
        fl = (o_deb == 0) && (hold == LC - 1) && (mr < 2);
        if (o_deb != 0) hold = 0;
        else if (hold < LC) hold++;
`endif
        prs = (debp == 1 && o_deb == 0) ? 1 : 0;
        debp = o_deb;
        if (o_s2 != o_deb) begin
            run++;
            if (run == DB) begin
                deb = o_s2;
                run = 0;
            end
        end else begin
            run = 0;
        end
        s2 = s1;
        s1 = b;
        if (ch) begin
            pos = 0; dir = 0; paused = 0; cnt = 0;
        end else begin
            case (mr)
                0: if (o_press != 0) pos = dir ? (pos + NO - 1) % NO : (pos + 1) % NO;
                1: begin
                    paused ^= o_press;
                    if (tk && paused == 0)
                        pos = dir ? (pos + NO - 1) % NO : (pos + 1) % NO;
                end
                2: begin
                    paused ^= o_press;
                    if (tk && paused == 0) begin
                        if (dir == 0 && pos == NO - 1) begin dir = 1; pos = NO - 2; end
                        else if (dir == 1 && pos == 0) begin dir = 0; pos = 1; end
                        else pos = dir ? pos - 1 : pos + 1;
                    end
                end
                default: begin
                    if (o_press != 0) cnt = 0;
                    else if (tk) cnt = (cnt + 1) % (1 << NO);
                end
            endcase
            if (fl) dir ^= 1;
        end
        pre = (pre + 1) % (1 << LD);
        ml = mr;
        mr = m;
    endtask

    task automatic cyc(input bit r, input bit b, input int m);
        RST = r;
        BTN_N = b;
        MODE = 2'(m);
        @(posedge CLK);
        model_step(r, b, m);
        @(negedge CLK);
        chk("out", 32'(OUT), m_out());
        chk("pos", 32'(POS), pos);
        chk("led", 32'(LED_N), deb);
    endtask

    task automatic press_btn(input int m);
        repeat (8) cyc(0, 0, m);
        repeat (8) cyc(0, 1, m);
    endtask

    initial begin
        bit rb;
        int rm, rl;

        repeat (2) cyc(1, 1, 0);
        repeat (20) cyc(0, 1, 0);
        chk("rst_out", 32'(OUT), 1);
        chk("rst_pos", 32'(POS), 0);
        chk("rst_led", 32'(LED_N), 1);

        repeat (3) cyc(0, 0, 0);
        repeat (6) cyc(0, 1, 0);
        chk("glitch_pos", 32'(POS), 0);
        repeat (10) cyc(0, 0, 0);
        chk("hold_led", 32'(LED_N), 0);
        chk("hold_pos", 32'(POS), 1);
        repeat (8) cyc(0, 1, 0);
        repeat (6) press_btn(0);
        chk("step7", 32'(POS), 7);
        press_btn(0);
        chk("step_wrap", 32'(POS), 0);

        repeat (70) cyc(0, 1, 1);
        press_btn(1);
        repeat (24) cyc(0, 1, 1);
        press_btn(1);
        repeat (24) cyc(0, 1, 1);

        repeat (130) cyc(0, 1, 2);
        press_btn(2);
        repeat (20) cyc(0, 1, 2);
        press_btn(2);
        repeat (37) cyc(0, 1, 2);
        cyc(0, 1, 1);
        cyc(0, 1, 1);
        chk("modechg_pos", 32'(POS), 0);

        repeat (2) cyc(0, 1, 3);
        chk("cnt_zero", 32'(OUT), 0);
        repeat (255 * 8) cyc(0, 1, 3);
        press_btn(3);
        repeat (40) cyc(0, 1, 3);

        repeat (2) cyc(0, 1, 0);
        repeat (40) cyc(0, 0, 0);
        repeat (10) cyc(0, 1, 0);
        chk("long_pos", 32'(POS), 1);
        press_btn(0);
`ifdef PMOD_WALKER_LONGPRESS_EN
        chk("long_p1", 32'(POS), 0);
`else
        chk("long_p1", 32'(POS), 2);
`endif
        press_btn(0);
`ifdef PMOD_WALKER_LONGPRESS_EN
        chk("long_p2", 32'(POS), 7);
`else
        chk("long_p2", 32'(POS), 3);
`endif

        repeat (12) cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("midrst_out", 32'(OUT), 1);
        chk("midrst_pos", 32'(POS), 0);
        chk("midrst_led", 32'(LED_N), 1);
        repeat (10) cyc(0, 0, 0);
        chk("midrst_press", 32'(POS), 1);
        repeat (10) cyc(0, 1, 0);

        rb = 1'b1;
        rm = 0;
        rl = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(199) == 0) rm = int'($urandom_range(3));
            if (rl == 0) begin
                rb = ~rb;
                rl = int'($urandom_range(20, 1));
            end
            rl--;
            cyc($urandom_range(999) == 0, rb, rm);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
